mem_port_arbiter: RTL

Two-master arbiter sharing the single dram_ctrl port between the I-cache (read-only refill) and the D-cache (refill and write-back). It grants the port to one cache at a time and holds that grant for the whole multi-beat burst. It forwards the granted cache's address, data and ctrl to dram_ctrl, and returns dram status and data only to the granted cache. The non-granted cache sees a busy status, so its refill/write-back FSM stalls in place. Sits between the cache pair and dram_ctrl.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_pick2.sv | 14 +
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the cache/dram_ctrl port arbiter: FSM states and dram
// status/ctrl constants. dcache and dram_ctrl use the same status encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2,
    HANDOFF  = 2'd3
  } arb_state_t;

  localparam logic [1:0] DRAM_READY = 2'b00;
  localparam logic [1:0] DRAM_BUSY  = 2'b01;
  localparam logic [2:0] CTRL_NONE  = 3'b000;

endpackage

// File: rtl/rr_pick2.sv
// Two-way combinational pick: a lone requester wins outright, a tie goes to
// the side selected by rr_ptr_i (1 = D-cache, 0 = I-cache).
module rr_pick2 (
  input  logic icache_req_i,
  input  logic dcache_req_i,
  input  logic rr_ptr_i,
  output logic gnt_icache_o,
  output logic gnt_dcache_o
);

  assign gnt_dcache_o = dcache_req_i && (!icache_req_i ||  rr_ptr_i);
  assign gnt_icache_o = icache_req_i && (!dcache_req_i || !rr_ptr_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single dram_ctrl port between I-cache and D-cache, holding
// the grant for a whole burst and inserting one idle HANDOFF cycle between owners.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int   ADDR_WIDTH = 64,
  parameter int   DATA_WIDTH = 64,
  parameter logic D_FIRST    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_rd_ctrl,
  output logic [DATA_WIDTH-1:0] i_dout,
  output logic [1:0]            i_state,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_din,
  input  logic [2:0]            d_rd_ctrl,
  input  logic [2:0]            d_wr_ctrl,
  output logic [DATA_WIDTH-1:0] d_dout,
  output logic [1:0]            d_state,
  input  logic [1:0]            state,
  input  logic [DATA_WIDTH-1:0] dram_dout,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [DATA_WIDTH-1:0] dram_din,
  output logic [2:0]            dram_rd_ctrl,
  output logic [2:0]            dram_wr_ctrl,
  output logic                  grant_i,
  output logic                  grant_d
);

  arb_state_t state_q, state_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic       req_i, req_d, pick_i, pick_d, beat_done;

  assign req_i     = |i_rd_ctrl;
  assign req_d     = (|d_rd_ctrl) | (|d_wr_ctrl);
  assign beat_done = (state == DRAM_READY);

  rr_pick2 u_pick (
    .icache_req_i (req_i),
    .dcache_req_i (req_d),
    .rr_ptr_i     (rr_ptr_q),
    .gnt_icache_o (pick_i),
    .gnt_dcache_o (pick_d)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_d) begin
          state_d  = OWN_D;
          rr_ptr_d = 1'b0;
        end else if (pick_i) begin
          state_d  = OWN_I;
          rr_ptr_d = 1'b1;
        end
      end
      // An owner that drops its request mid-beat keeps the port until the beat completes.
      OWN_I:   if (!req_i && beat_done) state_d = HANDOFF;
      OWN_D:   if (!req_d && beat_done) state_d = HANDOFF;
      HANDOFF: state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= D_FIRST;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    dram_addr    = '0;
    dram_din     = '0;
    dram_rd_ctrl = CTRL_NONE;
    dram_wr_ctrl = CTRL_NONE;
    i_dout       = '0;
    d_dout       = '0;
    i_state      = DRAM_BUSY;
    d_state      = DRAM_BUSY;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    unique case (state_q)
      OWN_I: begin
        grant_i      = 1'b1;
        dram_addr    = i_addr;
        dram_rd_ctrl = i_rd_ctrl;
        i_state      = state;
        i_dout       = dram_dout;
      end
      OWN_D: begin
        grant_d      = 1'b1;
        dram_addr    = d_addr;
        dram_din     = d_din;
        dram_rd_ctrl = d_rd_ctrl;
        dram_wr_ctrl = d_wr_ctrl;
        d_state      = state;
        d_dout       = dram_dout;
      end
      default: ;
    endcase
  end

endmodule
